pwl_act_unit: RTL and testbench
===============================

// Module: pwl_act_unit
// PURPOSE
//  Parametrised, pipelined piecewise-linear activation unit for the LSTM gate NNs.
//  Indexes a signed LUT with the top input bits and linearly interpolates between
//  adjacent entries with the fraction bits. Holds a sigmoid table and a tanh table,
//  selected per transaction. Replaces the per-gate fixed ROM LUTs; sits between
//  each layer's MAC output and the gate/cell-state logic.
// PARAMETERS
//  DATA_W  8  signed width of LUT entries and of y
//  ADDR_W  4  LUT index bits; depth = 2**ADDR_W per table
//  FRAC_W  4  interpolation fraction bits; input width IN_W = ADDR_W+FRAC_W
//  TAG_W   4  sideband tag carried alongside each sample (channel/lane id)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous, active-low reset
//  in_valid   in   1       input sample valid
//  in_ready   out  1       unit accepts a sample this cycle
//  in_x       in   IN_W    signed two's-complement input, x = {addr, frac}
//  in_mode    in   1       0 = sigmoid table, 1 = tanh table
//  in_tag     in   TAG_W   sideband, returned unchanged on out_tag
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  out_y      out  DATA_W  signed activation result
//  out_tag    out  TAG_W   tag of the sample on out_y
//  lut_we     in   1       LUT write strobe (PWL_ACT_LUTWR_EN only)
//  lut_sel    in   1       table to write: 0 sigmoid, 1 tanh
//  lut_addr   in   ADDR_W  entry index
//  lut_wdata  in   DATA_W  signed entry value
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): out_valid=0, out_y=0, out_tag=0, all stage valids=0,
//    both tables reload defaults. in_ready=1 out of reset.
//  - Defaults (DATA_W=8, ADDR_W=4), index 0..15:
//    sigmoid {8,11,14,15,15,15,15,15,0,0,0,0,0,0,1,4}
//    tanh    {0,3,5,6,7,7,7,7,-7,-7,-7,-7,-7,-6,-5,-3}
//    Other parameter sets: defaults are 0; tables must be loaded via the write port.
//  - Pipeline: S0 register x/mode/tag; S1 read base=T[a], next=T[n];
//    S2 interpolate into out_y. Latency 3 cycles accept->out_valid with no stall.
//  - Handshake: adv = !out_valid || out_ready; in_ready = adv; all stages shift
//    together on adv, else hold (full stall, no bubble collapse). Sample accepted
//    when in_valid && in_ready. Order preserved; no drop, no duplicate.
//  - Index a = x[IN_W-1:FRAC_W] (unsigned index of signed range; upper half = negative x).
//    next index n: a == 2**(ADDR_W-1)-1 (largest positive) -> n = a (saturate);
//    a == 2**ADDR_W-1 (all ones, just below 0) -> n = 0 (wrap across zero);
//    else n = a+1.
//  - Arithmetic: d = next-base (DATA_W+1 signed); p = d * {1'b0,frac} (exact);
//    y = base + (p >>> FRAC_W) (arithmetic shift, floor); result saturated to
//    DATA_W signed range [-2**(DATA_W-1), 2**(DATA_W-1)-1].
//  - LUT write takes effect on the following cycle; a lookup in S1 in the same
//    cycle as a write to its entry reads the old value.
//  - Reset mid-operation discards all in-flight samples; no out_valid for them.
// CONFIGURATION
//  PWL_ACT_LUTWR_EN defined: tables are registers, writable via lut_* ports.
//  Not defined: tables are constant ROM holding the defaults; lut_* ports remain
//  in the port list and are ignored.
// TESTING
//  1 sigmoid, x=0x18 (a=1,f=8): base 11,next 14 -> out_y=12, out_valid 3 cycles later.
//  2 sigmoid x=0x7F -> 15 (saturated next); x=0xF8 (a=15 wraps to 0) -> 6.
//  3 tanh x=0x08 -> 1; x=0xE8 (base -5,next -3) -> -4; x=0x88 -> -7.
//  4 stream 8 samples, out_ready=0 for 5 cycles mid-stream: in_ready=0 while stalled,
//    all 8 results emitted in order with matching out_tag, none lost.
//  5 LUTWR_EN: write sigmoid[1]=20, then x=0x18 -> 17; same-cycle write+lookup of
//    entry 1 -> old value used; other entries unchanged.
//  6 rst=0 with 3 samples in flight: no out_valid after reset; tables back to
//    defaults (x=0x18 -> 12 again).

Source files
------------

// File: rtl/pwl_act_unit.sv
// ---------------------------------------------------------------------------
// pwl_act_unit
//
// Pipelined piecewise-linear activation unit for the LSTM gate networks.
// The upper ADDR_W bits of the signed input select a LUT entry, the lower
// FRAC_W bits linearly interpolate towards the neighbouring entry. Two tables
// are held, sigmoid and tanh, and the table is chosen per sample by in_mode.
//
// Pipeline (all stages advance together, full stall on backpressure):
//   S0  register x / mode / tag
//   S1  read base = T[a] and next = T[n]
//   S2  interpolate, saturate, present on out_y
// Accept -> out_valid latency is 3 cycles when not stalled.
//
// Configuration macro:
//   PWL_ACT_LUTWR_EN  defined     : tables are registers, writable via lut_*
//                     not defined : tables are constant ROM with the defaults,
//                                   lut_* ports are present but ignored
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous, active-low reset
//   in_valid   in   1        input sample valid
//   in_ready   out  1        unit accepts a sample this cycle
//   in_x       in   IN_W     signed input {addr, frac}
//   in_mode    in   1        0 = sigmoid table, 1 = tanh table
//   in_tag     in   TAG_W    sideband, returned on out_tag
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   out_y      out  DATA_W   signed activation result
//   out_tag    out  TAG_W    tag of the sample on out_y
//   lut_we     in   1        LUT write strobe
//   lut_sel    in   1        table to write: 0 sigmoid, 1 tanh
//   lut_addr   in   ADDR_W   entry index
//   lut_wdata  in   DATA_W   signed entry value
// ---------------------------------------------------------------------------
module pwl_act_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W+FRAC_W-1:0]   in_x,
    input  logic                       in_mode,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_y,
    output logic [TAG_W-1:0]           out_tag,
    input  logic                       lut_we,
    input  logic                       lut_sel,
    input  logic [ADDR_W-1:0]          lut_addr,
    input  logic signed [DATA_W-1:0]   lut_wdata
);

    localparam int IN_W   = ADDR_W + FRAC_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + FRAC_W + 2;
    localparam int SUM_W  = PROD_W + 1;
    localparam int Y_MAX  = (1 << (DATA_W - 1)) - 1;
    localparam int Y_MIN  = -(1 << (DATA_W - 1));

    localparam logic [ADDR_W-1:0] IDX_POS_MAX  = ADDR_W'(DEPTH / 2 - 1);
    localparam logic [ADDR_W-1:0] IDX_ALL_ONES = ADDR_W'(DEPTH - 1);

    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(Y_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(Y_MIN);

    // The built-in default curves only make sense for the 8-bit / 16-entry
    // geometry; any other geometry starts from all-zero tables.
    localparam bit HAS_DEFAULTS = (DATA_W == 8) && (ADDR_W == 4);

    typedef logic signed [DATA_W-1:0] entry_t;

    // Default table contents, indexed by table select and entry number.
    function automatic entry_t default_entry(input logic sel, input int idx);
        int v;
        v = 0;
        if (HAS_DEFAULTS) begin
            if (!sel) begin
                case (idx)
                    0:       v = 8;
                    1:       v = 11;
                    2:       v = 14;
                    3:       v = 15;
                    4:       v = 15;
                    5:       v = 15;
                    6:       v = 15;
                    7:       v = 15;
                    14:      v = 1;
                    15:      v = 4;
                    default: v = 0;
                endcase
            end else begin
                case (idx)
                    0:       v = 0;
                    1:       v = 3;
                    2:       v = 5;
                    3:       v = 6;
                    4:       v = 7;
                    5:       v = 7;
                    6:       v = 7;
                    7:       v = 7;
                    8:       v = -7;
                    9:       v = -7;
                    10:      v = -7;
                    11:      v = -7;
                    12:      v = -7;
                    13:      v = -6;
                    14:      v = -5;
                    15:      v = -3;
                    default: v = 0;
                endcase
            end
        end
        return entry_t'(v);
    endfunction

    // -----------------------------------------------------------------------
    // Pipeline state
    // -----------------------------------------------------------------------
    logic               s0_valid_q, s0_valid_d;
    logic [IN_W-1:0]    s0_x_q,     s0_x_d;
    logic               s0_mode_q,  s0_mode_d;
    logic [TAG_W-1:0]   s0_tag_q,   s0_tag_d;

    logic               s1_valid_q, s1_valid_d;
    entry_t             s1_base_q,  s1_base_d;
    entry_t             s1_next_q,  s1_next_d;
    logic [FRAC_W-1:0]  s1_frac_q,  s1_frac_d;
    logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;

    logic               out_valid_q, out_valid_d;
    entry_t             out_y_q,     out_y_d;
    logic [TAG_W-1:0]   out_tag_q,   out_tag_d;

    logic               adv;

    // Read views of the two tables, whichever way they are implemented.
    entry_t             sig_tab  [DEPTH];
    entry_t             tanh_tab [DEPTH];

    // -----------------------------------------------------------------------
    // Table storage
    // -----------------------------------------------------------------------
`ifdef PWL_ACT_LUTWR_EN
    entry_t             sig_tab_q  [DEPTH];
    entry_t             sig_tab_d  [DEPTH];
    entry_t             tanh_tab_q [DEPTH];
    entry_t             tanh_tab_d [DEPTH];

    // A write lands at the next clock edge, so a lookup in S1 during the
    // write cycle still sees the previous entry value.
    always_comb begin
        sig_tab_d  = sig_tab_q;
        tanh_tab_d = tanh_tab_q;
        if (lut_we) begin
            if (lut_sel) begin
                tanh_tab_d[lut_addr] = lut_wdata;
            end else begin
                sig_tab_d[lut_addr] = lut_wdata;
            end
        end
    end

    // Table registers reload their defaults on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sig_tab_q[i]  <= default_entry(1'b0, i);
                tanh_tab_q[i] <= default_entry(1'b1, i);
            end
        end else begin
            sig_tab_q  <= sig_tab_d;
            tanh_tab_q <= tanh_tab_d;
        end
    end

    always_comb begin
        sig_tab  = sig_tab_q;
        tanh_tab = tanh_tab_q;
    end
`else
    logic               unused_lut;

    // Constant ROM; the write port has no effect in this build.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sig_tab[i]  = default_entry(1'b0, i);
            tanh_tab[i] = default_entry(1'b1, i);
        end
    end

    assign unused_lut = ^{lut_we, lut_sel, lut_addr, lut_wdata};
`endif

    // -----------------------------------------------------------------------
    // Handshake: the whole pipe moves only when the output slot is free or
    // being drained, so in_ready is simply the advance condition.
    // -----------------------------------------------------------------------
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // -----------------------------------------------------------------------
    // S1 lookup: index from the top bits, neighbour index with saturation at
    // the largest positive entry and a wrap from -1 up to entry 0.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0]  idx_a;
    logic [ADDR_W-1:0]  idx_n;
    entry_t             rd_base;
    entry_t             rd_next;

    always_comb begin
        idx_a = s0_x_q[IN_W-1:FRAC_W];
        if (idx_a == IDX_POS_MAX) begin
            idx_n = idx_a;
        end else if (idx_a == IDX_ALL_ONES) begin
            idx_n = '0;
        end else begin
            idx_n = idx_a + ADDR_W'(1);
        end
        if (s0_mode_q) begin
            rd_base = tanh_tab[idx_a];
            rd_next = tanh_tab[idx_n];
        end else begin
            rd_base = sig_tab[idx_a];
            rd_next = sig_tab[idx_n];
        end
    end

    // -----------------------------------------------------------------------
    // S2 interpolation: y = base + floor((next - base) * frac / 2**FRAC_W),
    // evaluated wide enough to be exact and then clamped to DATA_W.
    // -----------------------------------------------------------------------
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_sh;
    logic signed [SUM_W-1:0]  sum;
    entry_t                   interp_y;

    always_comb begin
        diff    = DIFF_W'(s1_next_q) - DIFF_W'(s1_base_q);
        prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, s1_frac_q}));
        prod_sh = prod >>> FRAC_W;
        sum     = SUM_W'(s1_base_q) + SUM_W'(prod_sh);
        if (sum > SUM_MAX) begin
            interp_y = entry_t'(Y_MAX);
        end else if (sum < SUM_MIN) begin
            interp_y = entry_t'(Y_MIN);
        end else begin
            interp_y = sum[DATA_W-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Stage next-state: everything holds unless the pipe advances. Payload
    // registers only load behind a valid sample so idle slots do not toggle.
    // -----------------------------------------------------------------------
    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_x_d      = s0_x_q;
        s0_mode_d   = s0_mode_q;
        s0_tag_d    = s0_tag_q;
        s1_valid_d  = s1_valid_q;
        s1_base_d   = s1_base_q;
        s1_next_d   = s1_next_q;
        s1_frac_d   = s1_frac_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_tag_d   = out_tag_q;

        if (adv) begin
            s0_valid_d  = in_valid;
            s1_valid_d  = s0_valid_q;
            out_valid_d = s1_valid_q;

            if (in_valid) begin
                s0_x_d    = in_x;
                s0_mode_d = in_mode;
                s0_tag_d  = in_tag;
            end
            if (s0_valid_q) begin
                s1_base_d = rd_base;
                s1_next_d = rd_next;
                s1_frac_d = s0_x_q[FRAC_W-1:0];
                s1_tag_d  = s0_tag_q;
            end
            if (s1_valid_q) begin
                out_y_d   = interp_y;
                out_tag_d = s1_tag_q;
            end
        end
    end

    // Pipeline registers; reset drops every in-flight sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_valid_q  <= 1'b0;
            s0_x_q      <= '0;
            s0_mode_q   <= 1'b0;
            s0_tag_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_base_q   <= '0;
            s1_next_q   <= '0;
            s1_frac_q   <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_x_q      <= s0_x_d;
            s0_mode_q   <= s0_mode_d;
            s0_tag_q    <= s0_tag_d;
            s1_valid_q  <= s1_valid_d;
            s1_base_q   <= s1_base_d;
            s1_next_q   <= s1_next_d;
            s1_frac_q   <= s1_frac_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pwl_act_unit.sv
// ---------------------------------------------------------------------------
// tb_pwl_act_unit
//
// Directed bench for pwl_act_unit with the default geometry (8-bit entries,
// 16-entry tables, 4 fraction bits, 4-bit tag). Expected results are worked
// out by hand from the default sigmoid / tanh tables. The LUT write checks
// are only built when PWL_ACT_LUTWR_EN is defined.
// ---------------------------------------------------------------------------
module tb_pwl_act_unit;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_x;
    logic              in_mode;
    logic [3:0]        in_tag;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_y;
    logic [3:0]        out_tag;
    logic              lut_we;
    logic              lut_sel;
    logic [3:0]        lut_addr;
    logic signed [7:0] lut_wdata;

    int n_compared;
    int n_mismatched;

    // Stream test vectors: x, mode, tag and the hand-computed result.
    logic [7:0] stream_x    [8] = '{8'h18, 8'h7F, 8'hF8, 8'h08, 8'hE8, 8'h88, 8'h00, 8'hF8};
    logic       stream_mode [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int         stream_y    [8] = '{12, 15, 6, 1, -4, -7, 8, -2};

    int  got_y   [$];
    int  got_tag [$];
    logic collect;

    pwl_act_unit #(
        .DATA_W (8),
        .ADDR_W (4),
        .FRAC_W (4),
        .TAG_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .lut_we    (lut_we),
        .lut_sel   (lut_sel),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result the downstream side takes, sampled mid-cycle.
    always @(negedge clk) begin
        if (collect && out_valid && out_ready) begin
            got_y.push_back(int'(out_y));
            got_tag.push_back(int'(out_tag));
        end
    end

    // Single point of comparison.
    task automatic checkOutput(input string name, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for a single accepting edge, then drop in_valid.
    task automatic applyStimulus(input logic [7:0] x, input logic mode, input logic [3:0] tag);
        in_valid = 1'b1;
        in_x     = x;
        in_mode  = mode;
        in_tag   = tag;
        stepClock();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the next result, check it, then let it drain.
    task automatic waitResult(input string name, input int exp_y, input int exp_tag,
                              output int waited);
        waited = 0;
        while (!out_valid && waited < 10) begin
            stepClock();
            waited++;
        end
        if (!out_valid) begin
            checkOutput({name, "_timeout"}, 0, 1);
        end else begin
            checkOutput({name, "_y"}, $signed(out_y), exp_y);
            checkOutput({name, "_tag"}, {28'd0, out_tag}, exp_tag);
            stepClock();
        end
    endtask

    initial begin
        int waited;
        int cyc;
        int sent;
        int seen_valid;
        logic acc;

        n_compared   = 0;
        n_mismatched = 0;
        collect      = 1'b0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_x         = '0;
        in_mode      = 1'b0;
        in_tag       = '0;
        out_ready    = 1'b1;
        lut_we       = 1'b0;
        lut_sel      = 1'b0;
        lut_addr     = '0;
        lut_wdata    = '0;

        repeat (3) stepClock();
        rst = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
        checkOutput("rst_out_y", $signed(out_y), 0);
        checkOutput("rst_out_tag", {28'd0, out_tag}, 0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
        stepClock();

        $display("[TB] single lookups");
        applyStimulus(8'h18, 1'b0, 4'd1);
        waitResult("sig_18", 12, 1, waited);
        checkOutput("sig_18_latency", waited + 1, 3);
        applyStimulus(8'h7F, 1'b0, 4'd2);
        waitResult("sig_7F_sat", 15, 2, waited);
        applyStimulus(8'hF8, 1'b0, 4'd3);
        waitResult("sig_F8_wrap", 6, 3, waited);
        applyStimulus(8'h08, 1'b1, 4'd4);
        waitResult("tanh_08", 1, 4, waited);
        applyStimulus(8'hE8, 1'b1, 4'd5);
        waitResult("tanh_E8", -4, 5, waited);
        applyStimulus(8'h88, 1'b1, 4'd6);
        waitResult("tanh_88", -7, 6, waited);

        $display("[TB] stream with stall");
        got_y.delete();
        got_tag.delete();
        collect = 1'b1;
        sent    = 0;
        cyc     = 0;
        while ((sent < 8 || got_y.size() < 8) && cyc < 80) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_x     = stream_x[sent];
                in_mode  = stream_mode[sent];
                in_tag   = 4'(sent + 8);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            if (!out_ready && out_valid) begin
                checkOutput("stall_in_ready", {31'd0, in_ready}, 0);
            end
            stepClock();
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) stepClock();
        collect = 1'b0;
        checkOutput("stream_count", got_y.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_y.size()) begin
                checkOutput($sformatf("stream%0d_y", i), got_y[i], stream_y[i]);
                checkOutput($sformatf("stream%0d_tag", i), got_tag[i], i + 8);
            end
        end

`ifdef PWL_ACT_LUTWR_EN
        $display("[TB] table writes");
        lut_we    = 1'b1;
        lut_sel   = 1'b0;
        lut_addr  = 4'd1;
        lut_wdata = 8'sd20;
        stepClock();
        lut_we = 1'b0;
        applyStimulus(8'h18, 1'b0, 4'd1);
        waitResult("wr_sig_18", 17, 1, waited);
        applyStimulus(8'h11, 1'b0, 4'd2);
        waitResult("wr_sig_11_floor", 19, 2, waited);
        applyStimulus(8'h28, 1'b0, 4'd3);
        waitResult("wr_sig_28_other", 14, 3, waited);
        applyStimulus(8'h18, 1'b1, 4'd4);
        waitResult("wr_tanh_18_other", 4, 4, waited);
        // Sample sits in S0 while the write to entry 1 happens.
        applyStimulus(8'h18, 1'b0, 4'd5);
        lut_we    = 1'b1;
        lut_wdata = 8'sd50;
        stepClock();
        lut_we = 1'b0;
        waitResult("wr_same_cycle_old", 17, 5, waited);
        applyStimulus(8'h18, 1'b0, 4'd6);
        waitResult("wr_sig_18_new", 32, 6, waited);
`endif

        $display("[TB] reset with samples in flight");
        out_ready = 1'b0;
        applyStimulus(8'h18, 1'b0, 4'd1);
        applyStimulus(8'h08, 1'b1, 4'd2);
        applyStimulus(8'hE8, 1'b1, 4'd3);
        rst = 1'b0;
        stepClock();
        rst       = 1'b1;
        out_ready = 1'b1;
        checkOutput("midrst_out_y", $signed(out_y), 0);
        checkOutput("midrst_out_tag", {28'd0, out_tag}, 0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 1);
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen_valid++;
            stepClock();
        end
        checkOutput("midrst_no_out_valid", seen_valid, 0);
        applyStimulus(8'h18, 1'b0, 4'd7);
        waitResult("midrst_defaults", 12, 7, waited);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
